// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and instruction-fetch stage of the MIPS core.
// Fetches over a req/ack handshake, holds the instruction for execution,
// then selects the next PC (jr > j > branch > PC+4).
// Optional build macro: ALIGN_CHECK_EN (force-align jr targets, sticky misalign flag).
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] SignImm,
  input  logic [31:0] RegTarget,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misalign
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic        jr_misaligned;

  // Sequential + branch/jump target arithmetic, all modulo 2^32.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    branch_target = pc_plus4 + {SignImm[29:0], 2'b00};
`ifdef ALIGN_CHECK_EN
    jr_misaligned = (RegTarget[1:0] != 2'b00);
    jr_target     = {RegTarget[31:2], 2'b00};
`else
    jr_misaligned = 1'b0;
    jr_target     = RegTarget;
`endif
  end

  // Next-state, next-PC and instruction capture for the fetch/execute FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      RESET_HOLD: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          state_d = FETCH;
          if (JumpReg)    pc_d = jr_target;
          else if (Jump)  pc_d = jump_target;
          else if (PCSrc) pc_d = branch_target;
          else            pc_d = pc_plus4;
        end
      end
      default: state_d = RESET_HOLD;
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_HOLD;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Sticky flag: set by a misaligned jr taken in EXEC, cleared only by reset.
  always_comb begin
    misalign_d = misalign_q;
    if (state_q == EXEC && !stall && JumpReg && jr_misaligned) misalign_d = 1'b1;
  end

  // Misalign flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = jr_misaligned;
`endif

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = (state_q == EXEC);
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then randomized
// instruction stream, checked against a rule-level next-PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, stall, PCSrc, Jump, JumpReg, imem_ack;
  logic [31:0] SignImm, RegTarget, imem_rdata;
  logic        imem_req, InstrValid, misalign;
  logic [31:0] imem_addr, Instr, PC, PCPlus4;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_pc;
  logic        exp_mis;

  fetch_pc_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .Jump(Jump),
    .JumpReg(JumpReg), .SignImm(SignImm), .RegTarget(RegTarget),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .Instr(Instr), .InstrValid(InstrValid),
    .PC(PC), .PCPlus4(PCPlus4), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next-PC rule: jr > j > branch > PC+4, all modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
      input bit jr, input bit j, input bit br, input logic [31:0] imm, input logic [31:0] tgt);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (jr) begin
`ifdef ALIGN_CHECK_EN
      return tgt & 32'hFFFF_FFFC;
`else
      return tgt;
`endif
    end
    if (j)  return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    if (br) return p4 + imm * 4;
    return p4;
  endfunction

  // One instruction: FETCH (with delay cycles), EXEC (with stall cycles), next PC.
  task automatic run_instr(input int delay, input int stalls, input bit jr, input bit j,
      input bit br, input logic [31:0] imm, input logic [31:0] tgt, input logic [31:0] word);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_valid", {31'd0, InstrValid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      stall = 1'b1; JumpReg = 1'b1; Jump = 1'b1; PCSrc = 1'b1; RegTarget = $urandom;
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", {31'd0, InstrValid}, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = word; stall = 1'b1;
    tick();
    stall = 1'b0; JumpReg = 1'b0; Jump = 1'b0; PCSrc = 1'b0;
    chk("exec_valid", {31'd0, InstrValid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_instr", Instr, word);
    chk("exec_pc", PC, exp_pc);
    chk("exec_pcplus4", PCPlus4, exp_pc + 32'd4);
    for (int i = 0; i < stalls; i++) begin
      imem_ack = 1'b1; imem_rdata = ~word;
      stall = 1'b1; JumpReg = 1'b1; Jump = 1'b1; PCSrc = 1'b1;
      tick();
      chk("stall_valid", {31'd0, InstrValid}, 32'd1);
      chk("stall_pc", PC, exp_pc);
      chk("stall_instr", Instr, word);
    end
    imem_ack = 1'b0; stall = 1'b0;
    JumpReg = jr; Jump = j; PCSrc = br; SignImm = imm; RegTarget = tgt;
    exp_pc = model_next(exp_pc, word, jr, j, br, imm, tgt);
`ifdef ALIGN_CHECK_EN
    if (jr && tgt[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    tick();
    JumpReg = 1'b0; Jump = 1'b0; PCSrc = 1'b0;
    chk("next_pc", PC, exp_pc);
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
  endtask

  initial begin
    logic [31:0] tgt;
    int          kind;
    reset = 1'b1; stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    SignImm = '0; RegTarget = '0; imem_ack = 1'b0; imem_rdata = '0;
    exp_pc = RPC; exp_mis = 1'b0;

    tick();
    chk("rst_pc", PC, RPC);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_pcplus4", PCPlus4, RPC + 32'd4);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    reset = 1'b0;
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Sequential zero-wait fetches 0x400000, 0x400004, 0x400008, 0x40000C.
    for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 0, '0, '0, $urandom);
    chk("seq_pc", PC, 32'h0040_0010);
    // Backward branch.
    run_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFC, '0, $urandom);
    chk("branch_pc", PC, 32'h0040_0004);
    // Aligned jr back to 0x400000, then jump beating a taken branch.
    run_instr(0, 0, 1, 0, 0, '0, 32'h0040_0000, $urandom);
    run_instr(0, 0, 0, 1, 1, 32'h0000_0010, '0, 32'h0810_0008);
    chk("jump_pc", PC, 32'h0040_0020);
    // Ack three cycles late, then two stall cycles.
    run_instr(3, 2, 0, 0, 0, '0, '0, $urandom);
    // Misaligned jr, then one more instruction for stickiness.
    run_instr(0, 0, 1, 0, 0, '0, 32'h0040_0102, $urandom);
`ifdef ALIGN_CHECK_EN
    chk("jr_pc", PC, 32'h0040_0100);
    chk("jr_mis", {31'd0, misalign}, 32'd1);
`else
    chk("jr_pc", PC, 32'h0040_0102);
    chk("jr_mis", {31'd0, misalign}, 32'd0);
`endif
    run_instr(1, 1, 0, 0, 0, '0, '0, $urandom);
    // PC+4 wrap at the top of the address space.
    run_instr(0, 0, 1, 0, 0, '0, 32'hFFFF_FFFC, $urandom);
    chk("wrap_p4", PCPlus4, 32'h0000_0000);
    run_instr(0, 0, 0, 0, 0, '0, '0, $urandom);
    chk("wrap_pc", PC, 32'h0000_0000);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      tgt  = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                kind == 0, kind == 1 || kind == 4, kind == 2 || kind == 4,
                $urandom, tgt, $urandom);
    end

    // Reset asserted mid-FETCH; ack arrives only after release.
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_pc", PC, RPC);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, InstrValid}, 32'd0);
    chk("async_instr", Instr, 32'd0);
    chk("async_mis", {31'd0, misalign}, 32'd0);
    chk("async_p4", PCPlus4, RPC + 32'd4);
    tick();
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    chk("rehold_req", {31'd0, imem_req}, 32'd0);
    chk("rehold_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    imem_ack = 1'b0;
    exp_pc = RPC; exp_mis = 1'b0;
    chk("restart_instr", Instr, 32'd0);
    run_instr(0, 0, 0, 0, 0, '0, '0, $urandom);
    chk("restart_pc", PC, RPC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
